sprite_ram_loader: RTL and testbench

- Writable replacement for a fixed sprite ROM. It receives a serial pixel-bit stream and packs it into 32-bit rows in an internal 16x32 bitmap memory.
- Exposes an asynchronous read port with the same shape as the sprite ROMs: 4-bit row address in, 32-bit row data out. Existing sprite painters read it unchanged.
- Sits between the game-logic/loader side (writer) and the sprite painter (reader). Sprites can be changed at run time.

---
 rtl/sprite_ram_loader.sv | 123 ++++++++++++
 tb/tb_sprite_ram_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_ram_loader.sv
// Writable sprite bitmap: packs a serial pixel-bit stream into ROWS x COLS rows, async row read.
// Latency: COLS+1 cycles per row at full rate, done 1+ROWS*(COLS+1) cycles after start; reads are combinational.
// Backpressure: bit_ready high only in LOAD; bit_valid low stalls with no state change, no timeout.
module sprite_ram_loader #(
  parameter int COLS   = 32,
  parameter int ROWS   = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COLS-1:0]   rd_data
);

  // Counter must be able to hold the value COLS itself.
  localparam int CNT_W = $clog2(COLS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [COLS-1:0]   shreg_q, shreg_d;
  logic              mem_we;

  // Bitmap storage; deliberately not reset so sprites survive rst.
  logic [COLS-1:0]   mem [ROWS];

  // State, counters and shift register; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      row_q     <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      row_q     <= row_d;
      shreg_q   <= shreg_d;
    end
  end

  // Row commit; a reset in the WRITE cycle suppresses the write so a
  // partially trusted row never lands in memory.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[row_q] <= shreg_q;
    end
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    row_d     = row_q;
    shreg_d   = shreg_q;
    bit_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          bit_cnt_d = '0;
          row_d     = '0;
        end
      end
      S_LOAD: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
        if (bit_valid) begin
          // First bit shifts all the way up to the MSB (column 0).
          shreg_d   = {shreg_q[COLS-2:0], bit_in};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(COLS - 1)) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        bit_cnt_d = '0;
        if (row_q == ADDR_W'(ROWS - 1)) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + ADDR_W'(1);
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Asynchronous read; addresses past the last row read as blank.
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < (ADDR_W + 1)'(ROWS)) begin
      rd_data = mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed bench for sprite_ram_loader: loads, back-pressure, mid-load reset, readback table.
// Latency: checks done timing against 1+ROWS*(COLS+1) and the half-rate equivalent.
// Backpressure: bit_valid is driven per cycle, toggled against bit_ready in the half-rate load.
module tb_sprite_ram_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic        busy;
  logic        done;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;

  int n_cmp;
  int n_bad;

  logic [31:0] ld_rows [16];
  logic [31:0] snap_wr;
  logic [31:0] snap_after;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [8];

  sprite_ram_loader #(.COLS(32), .ROWS(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  // Streams ld_rows MSB first. Cycle 0 is the start cycle. rd_addr is held
  // at 5 so the row-5 commit can be observed at full rate (WRITE at cycle 198).
  task automatic run_load(input bit half_rate, input int abort_bits, input int start_again,
                          output int done_cyc, output int done_cnt, output int rdy_err);
    int k;
    bit tog;
    k = 0;
    tog = 1'b0;
    done_cyc = -1;
    done_cnt = 0;
    rdy_err = 0;
    @(negedge clk);
    start = 1'b1;
    bit_valid = 1'b0;
    rd_addr = 4'd5;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      start = (cyc == start_again);
      if (abort_bits >= 0 && k == abort_bits) begin
        rst = 1'b1;
        bit_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      if (half_rate) begin
        if (bit_ready) begin
          bit_valid = tog;
          tog = ~tog;
        end else begin
          bit_valid = 1'b1;
        end
      end else begin
        bit_valid = 1'b1;
      end
      bit_in = (k < 512) ? ld_rows[k / 32][31 - (k % 32)] : 1'b0;
      #1;
      if (!half_rate && cyc <= 528 && (bit_ready !== ((cyc % 33) != 0))) rdy_err++;
      if (cyc == 198) snap_wr = rd_data;
      if (cyc == 199) snap_after = rd_data;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bit_valid && bit_ready) k++;
      if (done_cyc >= 0 && cyc > done_cyc + 2) break;
    end
    bit_valid = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int dc;
    int dn;
    int re;
    int idle_err;
    logic [31:0] d;

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    start = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    rd_addr = 4'd0;
    snap_wr = '0;
    snap_after = '0;

    tbl[0] = '{4'd3,  32'hA5A5_0003};
    tbl[1] = '{4'd0,  32'hA5A5_0000};
    tbl[2] = '{4'd15, 32'hA5A5_000F};
    tbl[3] = '{4'd5,  32'hA5A5_0005};
    tbl[4] = '{4'd10, 32'hA5A5_000A};
    tbl[5] = '{4'd1,  32'hA5A5_0001};
    tbl[6] = '{4'd8,  32'hA5A5_0008};
    tbl[7] = '{4'd14, 32'hA5A5_000E};

    // Reset state.
    @(negedge clk);
    #1;
    chk("rst_ready", {31'd0, bit_ready}, 32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_done",  {31'd0, done},      32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Bit order: a lone leading 1 must land in bit 31.
    for (int r = 0; r < 16; r++) ld_rows[r] = 32'h0000_0100 * r;
    ld_rows[0] = 32'h8000_0000;
    run_load(1'b0, -1, 0, dc, dn, re);
    chk("order_done_cyc", 32'(dc), 32'd529);
    rd(4'd0, d);
    chk("order_msb", {31'd0, d[31]}, 32'd1);
    chk("order_row0", d, 32'h8000_0000);

    // Full-rate load with a stray start mid-load and row-5 read-during-write.
    for (int r = 0; r < 16; r++) ld_rows[r] = 32'hA5A5_0000 | r;
    run_load(1'b0, -1, 100, dc, dn, re);
    chk("full_done_cyc", 32'(dc), 32'd529);
    chk("full_done_cnt", 32'(dn), 32'd1);
    chk("full_ready_gaps", 32'(re), 32'd0);
    chk("rdw_old", snap_wr, 32'h0000_0500);
    chk("rdw_new", snap_after, 32'hA5A5_0005);
    #1;
    chk("full_back_idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd(tbl[i].addr, d);
      chk("readback", d, tbl[i].exp);
    end

    // Reset then idle with bit_valid high and no start: nothing moves, nothing written.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_err = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in = 1'b1;
      #1;
      if (bit_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) idle_err++;
    end
    bit_valid = 1'b0;
    chk("idle_outputs", 32'(idle_err), 32'd0);
    rd(4'd0, d);
    chk("retain_row0", d, 32'hA5A5_0000);
    rd(4'd7, d);
    chk("retain_row7", d, 32'hA5A5_0007);
    rd(4'd15, d);
    chk("retain_row15", d, 32'hA5A5_000F);

    // start together with rst: reset wins.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_beats_start", {31'd0, busy}, 32'd0);

    // Back-pressure: valid toggles each LOAD cycle, starting low.
    for (int r = 0; r < 16; r++) ld_rows[r] = 32'hFFFF_FFFF;
    run_load(1'b1, -1, 0, dc, dn, re);
    chk("bp_done_cyc", 32'(dc), 32'd1041);
    chk("bp_done_cnt", 32'(dn), 32'd1);
    rd(4'd0, d);
    chk("bp_row0", d, 32'hFFFF_FFFF);
    rd(4'd9, d);
    chk("bp_row9", d, 32'hFFFF_FFFF);
    rd(4'd15, d);
    chk("bp_row15", d, 32'hFFFF_FFFF);

    // Reset mid-load: preload zeros, then abort an all-ones load at 2 rows + 10 bits.
    for (int r = 0; r < 16; r++) ld_rows[r] = 32'h0000_0000;
    run_load(1'b0, -1, 0, dc, dn, re);
    chk("zero_done_cyc", 32'(dc), 32'd529);
    for (int r = 0; r < 16; r++) ld_rows[r] = 32'hFFFF_FFFF;
    run_load(1'b0, 74, 0, dc, dn, re);
    #1;
    chk("abort_done_cnt", 32'(dn), 32'd0);
    chk("abort_busy",  {31'd0, busy},      32'd0);
    chk("abort_ready", {31'd0, bit_ready}, 32'd0);
    rd(4'd0, d);
    chk("abort_row0", d, 32'hFFFF_FFFF);
    rd(4'd1, d);
    chk("abort_row1", d, 32'hFFFF_FFFF);
    rd(4'd2, d);
    chk("abort_row2", d, 32'h0000_0000);
    rd(4'd3, d);
    chk("abort_row3", d, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
